cic_comb_m256: RTL and testbench

CIC_COMB_M256 -- requirements
Module: cic_comb_m256

---
 rtl/cic_comb_m256_pkg.sv | 16 +
 rtl/cic_comb_m256_if.sv | 20 ++
 rtl/cic_comb_m256_comb_delay_ram.sv | 31 +++
 rtl/cic_comb_m256.sv | 127 ++++++++++++
 tb/tb_cic_comb_m256.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cic_comb_m256_pkg.sv
`default_nettype none
// ============================================================================
// cic_pkg : shared constants and pointer-width helper for the CIC comb stage
// Revision : 1.0
// ============================================================================
package cic_pkg;

  localparam int CIC_DW = 48;
  localparam int CIC_M  = 256;

  function automatic int ptr_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comb_m256_if.sv
`default_nettype none
// ============================================================================
// cic_comb_m256_if : sample stream in, comb result and primed status out
// Revision : 1.0
// ============================================================================
interface cic_comb_m256_if import cic_pkg::*; #(
  parameter int DW = CIC_DW
);

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          primed;

  modport master (output s_valid, s_data, input m_valid, m_data, primed);
  modport slave  (input s_valid, s_data, output m_valid, m_data, primed);

endinterface
`default_nettype wire

// File: rtl/cic_comb_m256_comb_delay_ram.sv
`default_nettype none
// ============================================================================
// comb_delay_ram : simple dual-port, read-first, registered-read M x DW RAM
// Revision : 1.0
// ============================================================================
module comb_delay_ram import cic_pkg::*; #(
  parameter int DW = CIC_DW,
  parameter int AW = ptr_width(CIC_M)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Contents are deliberately unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cic_comb_m256.sv
`default_nettype none
// ============================================================================
// cic_comb_m256 : CIC comb y[n] = x[n] - x[n-M], two-cycle latency
// Revision : 1.0
// ============================================================================
module cic_comb_m256 import cic_pkg::*; #(
  parameter int DW = CIC_DW,
  parameter int M  = CIC_M
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  cic_comb_m256_if.slave  bus
);

  localparam int            AW    = ptr_width(M);
  localparam int            CW    = AW + 1;
  localparam logic [CW-1:0] M_CNT = CW'(M);

  logic          accept;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dly_operand;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic          v0_q, v0_d;
  logic [DW-1:0] x0_q, x0_d;
  logic          zf0_q, zf0_d;
  logic          v1_q, v1_d;
  logic [DW-1:0] x1_q, x1_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic          zf1_q, zf1_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;

  assign accept = bus.s_valid & ~clear;

  comb_delay_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (bus.s_data),
    .re    (accept),
    .raddr (wr_ptr_q),
    .rdata (rd_data)
  );

  // Before priming the buffer may hold stale data, so the operand is forced to 0.
  assign dly_operand = zf1_q ? {DW{1'b0}} : rd1_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    primed_d  = primed_q;
    v0_d      = v0_q;
    x0_d      = x0_q;
    zf0_d     = zf0_q;
    v1_d      = v1_q;
    x1_d      = x1_q;
    rd1_d     = rd1_q;
    zf1_d     = zf1_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (clear) begin
      wr_ptr_d  = '0;
      cnt_d     = '0;
      primed_d  = 1'b0;
      v0_d      = 1'b0;
      v1_d      = 1'b0;
      m_valid_d = 1'b0;
    end else begin
      v0_d = bus.s_valid;
      if (bus.s_valid) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        x0_d     = bus.s_data;
        zf0_d    = ~primed_q;
        if (cnt_q != M_CNT) cnt_d = cnt_q + 1'b1;
      end
      primed_d = (cnt_d == M_CNT);
      v1_d = v0_q;
      if (v0_q) begin
        x1_d  = x0_q;
        rd1_d = rd_data;
        zf1_d = zf0_q;
      end
      m_valid_d = v1_q;
      if (v1_q) m_data_d = x1_q - dly_operand;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      v0_q      <= 1'b0;
      x0_q      <= '0;
      zf0_q     <= 1'b1;
      v1_q      <= 1'b0;
      x1_q      <= '0;
      rd1_q     <= '0;
      zf1_q     <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      primed_q  <= primed_d;
      v0_q      <= v0_d;
      x0_q      <= x0_d;
      zf0_q     <= zf0_d;
      v1_q      <= v1_d;
      x1_q      <= x1_d;
      rd1_q     <= rd1_d;
      zf1_q     <= zf1_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.primed  = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_comb_m256.sv
`default_nettype none
// ============================================================================
// tb_cic_comb_m256 : directed vector table plus multi-cycle comb sequences
// Revision : 1.0
// ============================================================================
module tb_cic_comb_m256;

  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic clk;
  logic resetn;
  logic clear;
  int   n_vec;
  int   n_err;

  cic_comb_m256_if #(.DW(48)) bus ();

  cic_comb_m256 #(.DW(48), .M(256)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [47:0] sd;
    logic        clr;
    logic        ev;
    logic [47:0] ed;
    logic        ep;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; applies inputs across one rising edge.
  task automatic cyc(input logic v, input logic [47:0] d, input logic c);
    bus.s_valid = v;
    bus.s_data  = d;
    clear       = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    clear       = 1'b0;
    #1;
    chk("rst_mvalid", 48'(bus.m_valid), 48'd0);
    chk("rst_mdata", bus.m_data, 48'd0);
    chk("rst_primed", 48'(bus.primed), 48'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [47:0] ramp_exp(input int j);
    return (j < 256) ? 48'(j) : 48'd256;
  endfunction

  task automatic ramp_check(input string nm, input int n);
    for (int k = 0; k < n + 2; k++) begin
      cyc(k < n, 48'(k), 1'b0);
      if (k < n) chk($sformatf("%s_primed%0d", nm, k), 48'(bus.primed), 48'(k >= 255));
      if (k >= 2) begin
        chk($sformatf("%s_mv%0d", nm, k), 48'(bus.m_valid), 48'd1);
        chk($sformatf("%s_md%0d", nm, k), bus.m_data, ramp_exp(k - 2));
      end else begin
        chk($sformatf("%s_mv%0d", nm, k), 48'(bus.m_valid), 48'd0);
      end
    end
    cyc(1'b0, 48'd0, 1'b0);
    chk($sformatf("%s_tail_mv", nm), 48'(bus.m_valid), 48'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [47:0] prev;
    logic [47:0] d;
    n_vec       = 0;
    n_err       = 0;
    resetn      = 1'b0;
    clear       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    //            sv    sd                   clr   ev    ed                   ep
    tbl[0]  = '{1'b1, 48'd7,               1'b0, 1'b0, 48'd0,               1'b0};
    tbl[1]  = '{1'b0, 48'd0,               1'b0, 1'b0, 48'd0,               1'b0};
    tbl[2]  = '{1'b1, 48'd9,               1'b0, 1'b1, 48'd7,               1'b0};
    tbl[3]  = '{1'b1, 48'hFFFF_FFFF_FFFD,  1'b0, 1'b0, 48'd7,               1'b0};
    tbl[4]  = '{1'b0, 48'd0,               1'b0, 1'b1, 48'd9,               1'b0};
    tbl[5]  = '{1'b0, 48'd0,               1'b0, 1'b1, 48'hFFFF_FFFF_FFFD,  1'b0};
    tbl[6]  = '{1'b1, 48'd20,              1'b1, 1'b0, 48'hFFFF_FFFF_FFFD,  1'b0};
    tbl[7]  = '{1'b1, 48'd21,              1'b0, 1'b0, 48'hFFFF_FFFF_FFFD,  1'b0};
    tbl[8]  = '{1'b0, 48'd0,               1'b0, 1'b0, 48'hFFFF_FFFF_FFFD,  1'b0};
    tbl[9]  = '{1'b0, 48'd0,               1'b0, 1'b1, 48'd21,              1'b0};
    tbl[10] = '{1'b0, 48'd0,               1'b0, 1'b0, 48'd21,              1'b0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].sv, tbl[i].sd, tbl[i].clr);
      chk($sformatf("tbl%0d_mv", i), 48'(bus.m_valid), 48'(tbl[i].ev));
      chk($sformatf("tbl%0d_md", i), bus.m_data, tbl[i].ed);
      chk($sformatf("tbl%0d_pr", i), 48'(bus.primed), 48'(tbl[i].ep));
    end

    // Ramp: output tracks input until primed, then settles at M.
    do_reset();
    ramp_check("ramp", 600);

    // Modular wrap: 5 - (2^48 - 1) = 6.
    do_reset();
    for (int k = 0; k < 256; k++) cyc(1'b1, ONES, 1'b0);
    chk("wrap_primed", 48'(bus.primed), 48'd1);
    cyc(1'b1, 48'd5, 1'b0);
    cyc(1'b0, 48'd0, 1'b0);
    chk("wrap_s255", bus.m_data, ONES);
    cyc(1'b0, 48'd0, 1'b0);
    chk("wrap_mv", 48'(bus.m_valid), 48'd1);
    chk("wrap_md", bus.m_data, 48'd6);

    // Sparse input: one acceptance every third cycle.
    do_reset();
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      d = 48'(1000 + i * 7);
      cyc(1'b1, d, 1'b0);
      chk($sformatf("sparse%0d_mv0", i), 48'(bus.m_valid), 48'd0);
      chk($sformatf("sparse%0d_md0", i), bus.m_data, prev);
      cyc(1'b0, 48'd0, 1'b0);
      chk($sformatf("sparse%0d_mv1", i), 48'(bus.m_valid), 48'd0);
      chk($sformatf("sparse%0d_md1", i), bus.m_data, prev);
      cyc(1'b0, 48'd0, 1'b0);
      chk($sformatf("sparse%0d_mv2", i), 48'(bus.m_valid), 48'd1);
      chk($sformatf("sparse%0d_md2", i), bus.m_data, d);
      prev = d;
    end

    // Clear colliding with sample 100 of a ramp.
    do_reset();
    for (int k = 0; k < 100; k++) cyc(1'b1, 48'(k), 1'b0);
    chk("clr_pre_md", bus.m_data, 48'd97);
    cyc(1'b1, 48'd100, 1'b1);
    chk("clr_edge_mv", 48'(bus.m_valid), 48'd0);
    chk("clr_edge_pr", 48'(bus.primed), 48'd0);
    for (int j = 0; j < 300; j++) begin
      cyc(1'b1, 48'(101 + j), 1'b0);
      chk($sformatf("clr_pr%0d", j), 48'(bus.primed), 48'(j >= 255));
      if (j >= 2) begin
        chk($sformatf("clr_mv%0d", j), 48'(bus.m_valid), 48'd1);
        chk($sformatf("clr_md%0d", j), bus.m_data,
            (j - 2 < 256) ? 48'(101 + j - 2) : 48'd256);
      end else begin
        chk($sformatf("clr_mv%0d", j), 48'(bus.m_valid), 48'd0);
        chk($sformatf("clr_hold%0d", j), bus.m_data, 48'd97);
      end
    end

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int k = 0; k < 300; k++) cyc(1'b1, 48'(k), 1'b0);
    chk("arst_pre_pr", 48'(bus.primed), 48'd1);
    chk("arst_pre_mv", 48'(bus.m_valid), 48'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 48'd300;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_mv", 48'(bus.m_valid), 48'd0);
    chk("arst_md", bus.m_data, 48'd0);
    chk("arst_pr", 48'(bus.primed), 48'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    ramp_check("post_rst", 600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
